// File: rtl/fir_pkg.sv
// Package for the transposed-form FIR filter.
// Holds the default parameter values, the tap index type for the default tap
// count, and the round / shift / saturate helper used by the output stage.
package fir_pkg;

  localparam int NTAPS_DEF = 16;
  localparam int DW_DEF    = 18;
  localparam int CW_DEF    = 25;
  localparam int ACCW_DEF  = 48;
  localparam int OW_DEF    = 24;
  localparam int SHIFT_DEF = 23;

  // Working width of round_sat. Callers sign-extend their accumulator to
  // RS_W bits, so any ACCW below RS_W is supported.
  localparam int RS_W = 64;

  typedef logic [$clog2(NTAPS_DEF)-1:0] tap_idx_t;

  // {sat, value}: value is sign-extended to RS_W bits, so callers take the
  // low OW bits.
  typedef logic [RS_W:0] rs_t;

  // Rounds half up by adding 2^(shift-1), then shifts arithmetically right.
  // The result is clipped to the signed ow-bit range. A shift of 0 passes
  // the value through with no rounding. Two guard bits ensure that the
  // rounding add cannot wrap.
  function automatic rs_t round_sat(input logic signed [RS_W-1:0] acc,
                                    input int shift, input int ow);
    logic signed [RS_W+1:0] t;
    logic signed [RS_W+1:0] half;
    logic signed [RS_W+1:0] hi;
    logic signed [RS_W+1:0] lo;
    rs_t res;
    t = {{2{acc[RS_W-1]}}, acc};
    if (shift > 0) begin
      half = (RS_W+2)'(1) <<< (shift - 1);
      t    = t + half;
      t    = t >>> shift;
    end
    hi = ((RS_W+2)'(1) <<< (ow - 1)) - (RS_W+2)'(1);
    lo = ~hi;
    if (t > hi) begin
      res = {1'b1, hi[RS_W-1:0]};
    end else if (t < lo) begin
      res = {1'b1, lo[RS_W-1:0]};
    end else begin
      res = {1'b0, t[RS_W-1:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_tap_cell.sv
// One tap of the transposed FIR: a two-stage multiply.
//   S1 registers the sample and the coefficient, and loads only when valid_in is high.
//   S2 registers the full DW+CW product, sign-extended to ACCW, and loads only
//   when the S1 valid is high.
// The valid bits advance on every clock, whatever the state of the data registers.
// Ports:
//   clk, reset (async, active low)
//   valid_in   sample/coef qualifier
//   coef       signed coefficient h[k] from the active bank
//   sample     signed input sample
//   product    signed product, ACCW bits
//   valid_out  product valid, two clocks after valid_in
module fir_tap_cell
  import fir_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int CW   = CW_DEF,
  parameter int ACCW = ACCW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [CW-1:0]   coef,
  input  logic [DW-1:0]   sample,
  output logic [ACCW-1:0] product,
  output logic            valid_out
);

  logic signed [DW-1:0]    x_r;
  logic signed [CW-1:0]    h_r;
  logic                    v1;
  logic signed [DW+CW-1:0] prod_full;

  assign prod_full = $signed((DW+CW)'(x_r)) * $signed((DW+CW)'(h_r));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_r       <= '0;
      h_r       <= '0;
      v1        <= 1'b0;
      product   <= '0;
      valid_out <= 1'b0;
    end else begin
      v1        <= valid_in;
      valid_out <= v1;
      if (valid_in) begin
        x_r <= sample;
        h_r <= coef;
      end
      if (v1) begin
        product <= {{(ACCW-DW-CW){prod_full[DW+CW-1]}}, prod_full};
      end
    end
  end

endmodule

// File: rtl/fir_transposed_filter.sv
// Transposed-form FIR with NTAPS taps.
// The coefficient bank is double-buffered. Coefficients are written serially
// into the shadow bank. A commit then copies the whole shadow bank into the
// active bank in one step.
// The pipeline has four register stages:
//   S1, S2  tap cells (input and coefficient registers, then the product)
//   S3      partial-sum chain z and the full-precision accumulator
//   S4      round half up, arithmetic shift, saturate to OW bits
// Streaming: in_valid has no backpressure. Each sample that is accepted
// produces exactly one out_valid pulse. When there is a gap in in_valid,
// the z chain holds its state, so the filter counts only valid samples.
// Ports:
//   clk, reset (async, active low)
//   in_valid, in_data                     sample input
//   coef_wr_en, coef_wr_first             shadow write strobe; first restarts at index 0
//   coef_wr_data                          coefficient to write
//   coef_commit                           copy shadow bank to active bank
//   coef_pending                          shadow written since the last commit
//   out_valid, out_data, out_sat          filtered output and clip flag
module fir_transposed_filter
  import fir_pkg::*;
#(
  parameter int NTAPS = NTAPS_DEF,
  parameter int DW    = DW_DEF,
  parameter int CW    = CW_DEF,
  parameter int ACCW  = ACCW_DEF,
  parameter int OW    = OW_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          coef_wr_en,
  input  logic          coef_wr_first,
  input  logic [CW-1:0] coef_wr_data,
  input  logic          coef_commit,
  output logic          coef_pending,
  output logic          out_valid,
  output logic [OW-1:0] out_data,
  output logic          out_sat
);

  localparam int IW = $clog2(NTAPS);

  if (NTAPS < 2 || DW + CW + $clog2(NTAPS) > ACCW || ACCW >= RS_W ||
      OW > ACCW || SHIFT > ACCW - OW) begin : g_param_error
    $error("fir_transposed_filter: illegal parameter combination");
  end

  // ---------------------------------------------------------------
  // Coefficient banks
  // ---------------------------------------------------------------
  logic [CW-1:0] shadow [NTAPS];
  logic [CW-1:0] active [NTAPS];
  logic [IW-1:0] idx;

  // When a write and a commit happen on the same edge, the commit copies the
  // shadow contents from before the write, and coef_pending stays set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NTAPS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
      idx          <= '0;
      coef_pending <= 1'b0;
    end else begin
      if (coef_commit) begin
        for (int k = 0; k < NTAPS; k++) begin
          active[k] <= shadow[k];
        end
      end
      if (coef_wr_en) begin
        if (coef_wr_first) begin
          shadow[0] <= coef_wr_data;
          idx       <= IW'(1);
        end else begin
          shadow[idx] <= coef_wr_data;
          idx         <= (idx == IW'(NTAPS - 1)) ? '0 : idx + IW'(1);
        end
      end
      if (coef_wr_en) begin
        coef_pending <= 1'b1;
      end else if (coef_commit) begin
        coef_pending <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------
  // S1/S2: tap cells
  // ---------------------------------------------------------------
  logic [ACCW-1:0]  prod [NTAPS];
  logic [NTAPS-1:0] pv;
  logic             s2_valid;

  for (genvar k = 0; k < NTAPS; k++) begin : g_tap
    fir_tap_cell #(
      .DW   (DW),
      .CW   (CW),
      .ACCW (ACCW)
    ) u_cell (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (in_valid),
      .coef      (active[k]),
      .sample    (in_data),
      .product   (prod[k]),
      .valid_out (pv[k])
    );
  end

  // Every cell sees the same valid, so all the pv bits move together.
  assign s2_valid = &pv;

  // ---------------------------------------------------------------
  // S3: transposed partial-sum chain. The z registers load only on
  // valid products, so gaps in the input leave the filter history unchanged.
  // ---------------------------------------------------------------
  logic [ACCW-1:0] z [1:NTAPS-1];
  logic [ACCW-1:0] acc;
  logic            s3_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k < NTAPS; k++) begin
        z[k] <= '0;
      end
      acc      <= '0;
      s3_valid <= 1'b0;
    end else begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        z[NTAPS-1] <= prod[NTAPS-1];
        for (int k = 1; k < NTAPS - 1; k++) begin
          z[k] <= prod[k] + z[k+1];
        end
        acc <= prod[0] + z[1];
      end
    end
  end

  // ---------------------------------------------------------------
  // S4: round, shift, saturate
  // ---------------------------------------------------------------
  logic [RS_W-1:0]      acc_ext;
  rs_t                  rs;
  logic [RS_W-OW-1:0]   rs_hi_unused;

  assign acc_ext      = {{(RS_W-ACCW){acc[ACCW-1]}}, acc};
  assign rs           = round_sat(acc_ext, SHIFT, OW);
  // The value is already clipped to OW bits, so these upper bits are only
  // sign copies.
  assign rs_hi_unused = rs[RS_W-1:OW];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= s3_valid;
      if (s3_valid) begin
        out_data <= rs[OW-1:0];
        out_sat  <= rs[RS_W];
      end
    end
  end

endmodule

// File: tb/tb_fir_transposed_filter.sv
// Bench for fir_transposed_filter. Three instances share one stimulus
// stream. They differ only in SHIFT (0, 23 and 1).
// The reference model keeps one product vector x*h per accepted sample,
// using the bank that was active when that sample was accepted.
// y[n] = sum_k prod[n-k][k]
module tb_fir_transposed_filter;

  localparam int NT   = 16;
  localparam int DW   = 18;
  localparam int CW   = 25;
  localparam int OW   = 24;
  localparam int EW   = OW + 1;
  localparam int NDUT = 3;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          coef_wr_en = 1'b0;
  logic          coef_wr_first = 1'b0;
  logic [CW-1:0] coef_wr_data = '0;
  logic          coef_commit = 1'b0;

  logic          cp [NDUT];
  logic          ov [NDUT];
  logic [OW-1:0] od [NDUT];
  logic          os [NDUT];

  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int SHV = (g == 0) ? 0 : ((g == 1) ? 23 : 1);
    fir_transposed_filter #(.NTAPS(NT), .SHIFT(SHV)) u_dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .coef_wr_en    (coef_wr_en),
      .coef_wr_first (coef_wr_first),
      .coef_wr_data  (coef_wr_data),
      .coef_commit   (coef_commit),
      .coef_pending  (cp[g]),
      .out_valid     (ov[g]),
      .out_data      (od[g]),
      .out_sat       (os[g])
    );
  end

  function automatic int sh_of(input int i);
    case (i)
      0:       return 0;
      1:       return 23;
      default: return 1;
    endcase
  endfunction

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  longint         sh_m [NT];
  longint         act_m [NT];
  int             idx_m;
  logic           pend_m;
  longint         ph [NT][NT];
  logic [3*EW-1:0] exp_q[$];
  int             exp_t_q[$];

  function automatic logic [EW-1:0] ref_round(input longint y, input int sh);
    longint r, mx, mn;
    mx = (longint'(1) << (OW - 1)) - 1;
    mn = -(longint'(1) << (OW - 1));
    r  = (sh > 0) ? ((y + (longint'(1) << (sh - 1))) >>> sh) : y;
    if (r > mx) return {1'b1, mx[OW-1:0]};
    if (r < mn) return {1'b1, mn[OW-1:0]};
    return {1'b0, r[OW-1:0]};
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NT; k++) begin
      sh_m[k]  = 0;
      act_m[k] = 0;
      for (int j = 0; j < NT; j++) ph[j][k] = 0;
    end
    idx_m  = 0;
    pend_m = 1'b0;
    exp_q.delete();
    exp_t_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // This task drives one clock cycle of inputs and applies the same edge to
  // the model. At that edge a sample sees the old active bank, a commit
  // copies the old shadow bank, and then the write lands.
  task automatic cyc_drive(input bit v, input longint x, input bit we, input bit wf,
                           input longint wd, input bit cm);
    longint y;
    logic [3*EW-1:0] e;
    in_valid      = v;
    in_data       = x[DW-1:0];
    coef_wr_en    = we;
    coef_wr_first = wf;
    coef_wr_data  = wd[CW-1:0];
    coef_commit   = cm;
    if (v) begin
      for (int j = NT - 1; j > 0; j--)
        for (int k = 0; k < NT; k++) ph[j][k] = ph[j-1][k];
      for (int k = 0; k < NT; k++) ph[0][k] = x * act_m[k];
      y = 0;
      for (int k = 0; k < NT; k++) y += ph[k][k];
      for (int i = 0; i < NDUT; i++) e[i*EW +: EW] = ref_round(y, sh_of(i));
      exp_q.push_back(e);
      exp_t_q.push_back(cyc + 4);
    end
    if (cm) for (int k = 0; k < NT; k++) act_m[k] = sh_m[k];
    if (we) begin
      if (wf) begin
        sh_m[0] = wd;
        idx_m   = 1;
      end else begin
        sh_m[idx_m] = wd;
        idx_m = (idx_m == NT - 1) ? 0 : idx_m + 1;
      end
    end
    if (we) pend_m = 1'b1;
    else if (cm) pend_m = 1'b0;
    @(negedge clk);
    in_valid      = 1'b0;
    coef_wr_en    = 1'b0;
    coef_wr_first = 1'b0;
    coef_commit   = 1'b0;
    for (int i = 0; i < NDUT; i++)
      check_val($sformatf("coef_pending_sh%0d", sh_of(i)), 64'(cp[i]), 64'(pend_m));
  endtask

  task automatic idle(input int n);
    repeat (n) cyc_drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic send(input longint x);
    cyc_drive(1, x, 0, 0, 0, 0);
  endtask

  task automatic commit_bank();
    cyc_drive(0, 0, 0, 0, 0, 1);
  endtask

  function automatic longint rnd_sample();
    return longint'($urandom_range(0, 2000)) - 1000;
  endfunction

  // This task asserts reset between edges. It checks the outputs right away
  // while reset is held, then holds reset for n negedges before releasing it.
  task automatic apply_reset(input int n);
    #2 reset = 1'b0;
    model_clear();
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check_val($sformatf("rst_out_valid_sh%0d", sh_of(i)), 64'(ov[i]), 64'(0));
      check_val($sformatf("rst_out_data_sh%0d", sh_of(i)), 64'(od[i]), 64'(0));
      check_val($sformatf("rst_out_sat_sh%0d", sh_of(i)), 64'(os[i]), 64'(0));
      check_val($sformatf("rst_coef_pending_sh%0d", sh_of(i)), 64'(cp[i]), 64'(0));
    end
    repeat (n) @(negedge clk);
    #2 reset = 1'b1;
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    logic            exp_v;
    logic [3*EW-1:0] e;
    if (reset) begin
      exp_v = (exp_t_q.size() > 0) && (exp_t_q[0] == cyc);
      e     = exp_v ? exp_q[0] : '0;
      for (int i = 0; i < NDUT; i++) begin
        if (ov[i] || exp_v) begin
          check_val($sformatf("out_valid_sh%0d", sh_of(i)), 64'(ov[i]), 64'(exp_v));
          if (ov[i] && exp_v)
            check_val($sformatf("out_sat_data_sh%0d", sh_of(i)),
                      64'({os[i], od[i]}), 64'(e[i*EW +: EW]));
        end
      end
      if (exp_v) begin
        void'(exp_q.pop_front());
        void'(exp_t_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_clear();
    apply_reset(3);

    // Impulse response with h[k] = k+1.
    for (int k = 0; k < NT; k++) cyc_drive(0, 0, 1, k == 0, k + 1, 0);
    commit_bank();
    send(1);
    repeat (NT - 1) send(0);
    idle(6);

    // The same impulse, with a valid sample only on every third cycle.
    send(1);
    idle(2);
    repeat (NT - 1) begin
      send(0);
      idle(2);
    end
    idle(6);

    // Reload the bank while samples stream, then commit on a sample edge.
    for (int k = 0; k < NT; k++) cyc_drive(1, rnd_sample(), 1, k == 0, 100 - 7 * k, 0);
    cyc_drive(1, rnd_sample(), 0, 0, 0, 1);
    repeat (20) send(rnd_sample());
    idle(6);

    // Rounding with a single tap, h0 = 1.
    for (int k = 0; k < NT; k++) cyc_drive(0, 0, 1, k == 0, (k == 0) ? 1 : 0, 0);
    commit_bank();
    send(3);
    send(-3);
    send(5);
    send(-5);
    idle(6);

    // Saturation: every tap at its maximum, positive drive then negative drive.
    for (int k = 0; k < NT; k++) cyc_drive(0, 0, 1, k == 0, (longint'(1) << 24) - 1, 0);
    commit_bank();
    repeat (NT) send((longint'(1) << 17) - 1);
    repeat (NT) send(-(longint'(1) << 17));
    idle(6);

    // Index wrap: 17 plain writes starting at index 0; the last one lands in shadow[0].
    for (int i = 0; i < NT + 1; i++) cyc_drive(0, 0, 1, 0, 200 + i, 0);
    commit_bank();
    send(1);
    repeat (NT - 1) send(0);
    idle(6);

    // Reset mid-stream. This zeroes the banks, so later outputs are 0.
    repeat (5) send(rnd_sample());
    apply_reset(2);
    repeat (10) send(rnd_sample());
    idle(6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
